// File: rtl/adc_cap_pkg.sv
// rtl/adc_cap_pkg.sv - shared state type, fill constant and width helper for the ADC capture buffer
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    SETTLE,
    FILL,
    READY
  } cap_state_e;

  localparam logic [15:0] BAD_WORD_DEFAULT = 16'h0BAD;

  // level must represent 0..DEPTH inclusive, hence one bit beyond the pointer width
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/adc_cap_ram.sv
// rtl/adc_cap_ram.sv - simple dual-port RAM, one write port and one registered read port
module adc_cap_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  output logic [WIDTH-1:0]         rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // array is deliberately left without reset so it maps onto block RAM
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/adc_capture_buf.sv
// rtl/adc_capture_buf.sv - multi-channel ADC snapshot buffer with settle skip and host readback
// Define ADC_CAP_DECIM_EN to accept only every (decim+1)-th strobe during SETTLE and FILL.
module adc_capture_buf
  import adc_cap_pkg::*;
#(
  parameter int          NUM_CH   = 2,
  parameter int          DATA_W   = 16,
  parameter int          DEPTH    = 1024,
  parameter int          SKIP_W   = 8,
  parameter logic [15:0] BAD_WORD = BAD_WORD_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  input  logic                     start,
  input  logic [SKIP_W-1:0]        skip_cnt,
  input  logic [7:0]               decim,
  input  logic                     rd_req,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] rd_data,
  output logic                     rd_err,
  output logic                     busy,
  output logic                     ready,
  output logic [lvl_w(DEPTH)-1:0]  level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  localparam int VW = NUM_CH * DATA_W;
  localparam logic [DATA_W-1:0] BAD_CH  = DATA_W'(BAD_WORD);
  localparam logic [VW-1:0]     BAD_VEC = {NUM_CH{BAD_CH}};

  // reset asserts asynchronously but is released two clocks later, in step with clk
  logic [1:0] rst_sync_q;
  logic       rst_ni;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_ni = rst_sync_q[1];

  cap_state_e        state_q, state_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [SKIP_W-1:0] skip_q, skip_d;
  logic              accept;
  logic              rd_ok;
  logic              ram_we;
  logic [VW-1:0]     ram_rdata;

  logic              p1_valid_q, p1_err_q;
  logic              rd_valid_q, rd_err_q;
  logic [VW-1:0]     rd_data_q;

`ifdef ADC_CAP_DECIM_EN
  logic [7:0] decim_q, decim_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       in_cap;

  assign in_cap = (state_q == SETTLE) || (state_q == FILL);
  assign accept = s_valid && (dcnt_q == 8'd0);

  always_comb begin
    decim_d = decim_q;
    dcnt_d  = dcnt_q;
    if (start) begin
      decim_d = decim;
      dcnt_d  = 8'd0;
    end else if (state_q == FLUSH) begin
      dcnt_d = 8'd0;
    end else if (s_valid && in_cap) begin
      dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      decim_q <= 8'd0;
      dcnt_q  <= 8'd0;
    end else begin
      decim_q <= decim_d;
      dcnt_q  <= dcnt_d;
    end
  end
`else
  logic unused_decim;

  assign accept       = s_valid;
  assign unused_decim = ^decim;
`endif

  // a read issued alongside start is rejected: the buffer it targets is being abandoned
  assign rd_ok = rd_req && !start && (state_q == READY) && (level_q != '0);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    skip_d  = skip_q;
    ram_we  = 1'b0;
    if (start) begin
      state_d = FLUSH;
      skip_d  = skip_cnt;
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FLUSH: begin
          wptr_d  = '0;
          rptr_d  = '0;
          level_d = '0;
          state_d = (skip_q == '0) ? FILL : SETTLE;
        end
        SETTLE: begin
          if (skip_q == '0) begin
            state_d = FILL;
          end else if (accept) begin
            skip_d = skip_q - SKIP_W'(1);
            if (skip_q == SKIP_W'(1)) state_d = FILL;
          end
        end
        FILL: begin
          if (accept) begin
            ram_we  = 1'b1;
            wptr_d  = wptr_q + AW'(1);
            level_d = level_q + LW'(1);
            if (level_q == LW'(DEPTH - 1)) state_d = READY;
          end
        end
        READY: begin
          if (rd_ok) begin
            rptr_d  = rptr_q + AW'(1);
            level_d = level_q - LW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      skip_q  <= skip_d;
    end
  end

  adc_cap_ram #(
    .WIDTH(VW),
    .DEPTH(DEPTH)
  ) u_ram (
    .clk_i    (clk),
    .wr_en_i  (ram_we),
    .wr_addr_i(wptr_q),
    .wr_data_i(s_data),
    .rd_en_i  (rd_ok),
    .rd_addr_i(rptr_q),
    .rd_data_o(ram_rdata)
  );

  // stage 1 tracks the RAM access, stage 2 is the output register that holds between pulses
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      p1_valid_q <= 1'b0;
      p1_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      rd_data_q  <= BAD_VEC;
    end else begin
      p1_valid_q <= rd_req;
      p1_err_q   <= !rd_ok;
      rd_valid_q <= p1_valid_q;
      rd_err_q   <= p1_valid_q && p1_err_q;
      if (p1_valid_q) rd_data_q <= p1_err_q ? BAD_VEC : ram_rdata;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign busy     = (state_q == FLUSH) || (state_q == SETTLE) || (state_q == FILL);
  assign ready    = (state_q == READY) && (level_q != '0);
  assign level    = level_q;

endmodule

// File: tb/tb_adc_capture_buf.sv
// tb/tb_adc_capture_buf.sv - scoreboard bench for adc_capture_buf against a strobe-list reference model
module tb_adc_capture_buf;

  localparam int NUM_CH = 2;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int SKIP_W = 8;
  localparam int VW     = NUM_CH * DATA_W;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam logic [VW-1:0] BAD_VEC = {16'h0BAD, 16'h0BAD};

  typedef struct {
    logic [VW-1:0] data;
    bit            err;
    int            due;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic [VW-1:0]     s_data = '0;
  logic              start = 1'b0;
  logic [SKIP_W-1:0] skip_cnt = '0;
  logic [7:0]        decim = '0;
  logic              rd_req = 1'b0;
  logic              rd_valid, rd_err, busy, ready;
  logic [VW-1:0]     rd_data;
  logic [LW-1:0]     level;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // reference model: every accepted strobe since the last start, plus a count of good reads
  bit            m_active = 1'b0;
  bit            m_flush  = 1'b0;
  int            m_skip   = 0;
  int            m_dec    = 0;
  int            m_nstr   = 0;
  int            m_rd     = 0;
  logic [VW-1:0] m_acc[$];
  int            edge_n   = 0;
  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [VW-1:0] last_data = BAD_VEC;

  always #5 clk = ~clk;

  adc_capture_buf #(
    .NUM_CH(NUM_CH),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .SKIP_W(SKIP_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_data  (s_data),
    .start   (start),
    .skip_cnt(skip_cnt),
    .decim   (decim),
    .rd_req  (rd_req),
    .rd_valid(rd_valid),
    .rd_data (rd_data),
    .rd_err  (rd_err),
    .busy    (busy),
    .ready   (ready),
    .level   (level)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp_v, edge_n);
    end
  endtask

  function automatic bit m_full();
    return m_active && !m_flush && (m_acc.size() == m_skip + DEPTH);
  endfunction

  function automatic int m_level();
    int n;
    if (!m_active || m_flush) return 0;
    if (m_full()) return DEPTH - m_rd;
    n = m_acc.size() - m_skip;
    return (n < 0) ? 0 : n;
  endfunction

  function automatic bit m_busy();
    return m_active && !m_full();
  endfunction

  function automatic bit m_ready();
    return m_full() && (m_rd < DEPTH);
  endfunction

  function automatic logic [VW-1:0] ramp(input int n);
    return {16'(16'h8000 + n), 16'(n)};
  endfunction

  task automatic model_edge(input bit sv, input logic [VW-1:0] d, input bit st, input bit rr);
    exp_t e;
    edge_n++;
    if (rr) begin
      e.due = edge_n + 1;
      if (!st && m_full() && m_rd < DEPTH) begin
        e.err  = 1'b0;
        e.data = m_acc[m_skip + m_rd];
        m_rd++;
      end else begin
        e.err  = 1'b1;
        e.data = BAD_VEC;
      end
      exp_q.push_back(e);
    end
    if (st) begin
      m_active = 1'b1;
      m_flush  = 1'b1;
      m_acc.delete();
      m_nstr   = 0;
      m_rd     = 0;
      m_skip   = int'(skip_cnt);
`ifdef ADC_CAP_DECIM_EN
      m_dec    = int'(decim);
`else
      m_dec    = 0;
`endif
    end else if (m_flush) begin
      m_flush = 1'b0;
    end else if (m_active && !m_full() && sv) begin
      if (m_nstr % (m_dec + 1) == 0) m_acc.push_back(d);
      m_nstr++;
    end
  endtask

  task automatic tick(input bit sv, input logic [VW-1:0] d, input bit st, input bit rr);
    s_valid = sv;
    s_data  = d;
    start   = st;
    rd_req  = rr;
    @(posedge clk);
    model_edge(sv, d, st, rr);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic fill(input int pct);
    int n = 0;
    while (!m_full() && n < 400) begin
      tick($urandom_range(0, 99) < pct, VW'($urandom()), 1'b0, 1'b0);
      n++;
    end
    chk("fill_ready", ready, 1);
  endtask

  task automatic drain(input int pct);
    int n = 0;
    while (m_rd < DEPTH && n < 400) begin
      tick(1'b0, '0, 1'b0, $urandom_range(0, 99) < pct);
      n++;
    end
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(3);
    chk("drained_level", level, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("level", level, m_level());
      chk("busy", busy, m_busy());
      chk("ready", ready, m_ready());
      if (rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("rd_valid_unexpected", rd_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("rd_data", rd_data, mon_e.data);
          chk("rd_err", rd_err, mon_e.err);
          chk("rd_latency", edge_n, mon_e.due);
        end
        last_data = rd_data;
      end else begin
        chk("rd_hold", rd_data, last_data);
        chk("rd_err_idle", rd_err, 0);
        if (exp_q.size() > 0 && exp_q[0].due <= edge_n) begin
          chk("rd_valid_missing", rd_valid, 1);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    idle(3);
    rst_n = 1'b1;
    idle(3);
    @(negedge clk);
    chk("reset_rd_data", rd_data, BAD_VEC);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_level", level, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", ready, 0);
    chk_en = 1'b1;

    // read with nothing captured
    tick(1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // ramp capture with three settle samples, then 17 back-to-back reads
    skip_cnt = 8'd3;
    tick(1'b1, '1, 1'b1, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) tick(1'b1, ramp(i), 1'b0, 1'b0);
    chk("ramp_level", level, DEPTH);
    for (int i = 0; i < 17; i++) tick(1'b0, '0, 1'b0, 1'b1);
    idle(3);

    // start together with a read at fill level 7
    skip_cnt = 8'd2;
    tick(1'b0, '0, 1'b1, 1'b0);
    n = 0;
    while (!(m_level() == 7 && !m_full()) && n < 100) begin
      tick(1'b1, VW'($urandom()), 1'b0, 1'b0);
      n++;
    end
    chk("level7_reached", level, 7);
    tick(1'b1, VW'($urandom()), 1'b1, 1'b1);
    chk("restart_busy", busy, 1);
    chk("restart_level", level, 0);
    fill(70);

    // start while reads are still in flight
    tick(1'b0, '0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1);
    skip_cnt = 8'd1;
    tick(1'b0, '0, 1'b1, 1'b1);
    fill(100);
    drain(60);

    // gapped strobes, no settle skip
    skip_cnt = 8'd0;
    tick(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 60; i++) tick((i % 3) == 0, VW'($urandom()), 1'b0, 1'b0);
    chk("gapped_ready", ready, 1);
    drain(100);

    // decimation by 4 (only effective when compiled in)
    skip_cnt = 8'd0;
    decim    = 8'd3;
    tick(1'b1, '1, 1'b1, 1'b0);
    tick(1'b1, '1, 1'b0, 1'b0);
    for (int i = 0; i < 80; i++) tick(1'b1, ramp(i), 1'b0, 1'b0);
    drain(100);

    // randomised rounds with reads attempted during the capture
    for (int r = 0; r < 4; r++) begin
      skip_cnt = SKIP_W'($urandom_range(0, 4));
      decim    = 8'($urandom_range(0, 3));
      tick(1'b1, VW'($urandom()), 1'b1, 1'b0);
      n = 0;
      while (!m_full() && n < 500) begin
        tick($urandom_range(0, 99) < 60, VW'($urandom()), 1'b0, $urandom_range(0, 99) < 10);
        n++;
      end
      chk("round_ready", ready, 1);
      drain(70);
    end

    idle(4);
    chk("pending_reads", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
